// File: rtl/booth_pkg.sv
// Shared types and elaboration-time helpers for the radix-4 Booth multiplier.
// Tree-shape functions let the top size its CSA levels from the operand width.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  function automatic int npp(input int width);
    return width / 2 + 1;
  endfunction

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  function automatic int csa_rows(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = csa_rows(n);
    return n;
  endfunction

  function automatic int row_base(input int n0, input int lvl);
    int s;
    s = 0;
    for (int i = 0; i < lvl; i++) s += rows_at(n0, i);
    return s;
  endfunction

  function automatic int tree_depth(input int n0);
    int n;
    int d;
    n = n0;
    d = 0;
    while (n > 2) begin
      n = csa_rows(n);
      d++;
    end
    return d;
  endfunction

  // Each row carries an inverted sign bit at weight 2^(E+2i); this constant
  // removes the 2^(E+2i) those inversions add, so rows need no sign extension.
  function automatic logic [127:0] se_const(input int width);
    logic [127:0] acc;
    acc = '0;
    for (int i = 0; i < npp(width); i++) acc = acc + (128'd1 << (width + 2 + 2 * i));
    return ~acc + 128'd1;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: digit x extended multiplicand, in one's-complement
// form with the sign bit inverted; the +1 of negation is returned as o_neg.
module booth_pp_row
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_a_ext,
  input  booth_digit_t     i_digit,
  output logic [WIDTH+2:0] o_row,
  output logic             o_neg
);

  localparam int E = WIDTH + 2;

  logic [E:0] w_mag;
  logic [E:0] w_pp;

  always_comb begin
    case (i_digit)
      POS1, NEG1: w_mag = {i_a_ext[E-1], i_a_ext};
      POS2, NEG2: w_mag = {i_a_ext, 1'b0};
      default:    w_mag = '0;
    endcase
  end

  assign o_neg = (i_digit == NEG1) || (i_digit == NEG2);
  assign w_pp  = o_neg ? ~w_mag : w_mag;
  assign o_row = {~w_pp[E], w_pp[E-1:0]};

endmodule

// File: rtl/booth_mult_pipe.sv
// Three-stage radix-4 Booth / Wallace-tree multiplier, signed or unsigned per op,
// with a global-stall valid/ready pipeline and a tag sideband.
module booth_mult_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int E     = WIDTH + 2;
  localparam int P     = 2 * WIDTH;
  localparam int NPP   = npp(WIDTH);
  localparam int N0    = NPP + 2;
  localparam int DEPTH = tree_depth(N0);
  localparam int NALL  = row_base(N0, DEPTH + 1);
  localparam int FIN   = row_base(N0, DEPTH);
  localparam logic [P-1:0] SE_CONST = P'(se_const(WIDTH));

  logic             r_rdy;
  logic             r_v1, r_v2;
  logic [E-1:0]     r_a, r_b;
  logic [TAG_W-1:0] r_tag1, r_tag2;
  logic [P-1:0]     r_sum, r_carry;

  logic             w_adv, w_accept;
  booth_digit_t     w_digit [NPP];
  logic [E:0]       w_row   [NPP];
  logic [NPP-1:0]   w_neg;
  logic [P-1:0]     w_neg_row;
  logic [P-1:0]     w_all   [NALL];

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && r_rdy;
  assign w_accept = in_valid && in_ready;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_pp
      logic [2:0] w_win;
      if (gi == 0) begin : g_lsb
        assign w_win = {r_b[1:0], 1'b0};
      end else begin : g_mid
        assign w_win = r_b[2*gi+1 -: 3];
      end
      assign w_digit[gi] = booth_recode(w_win);
      booth_pp_row #(.WIDTH(WIDTH)) u_row (
        .i_a_ext (r_a),
        .i_digit (w_digit[gi]),
        .o_row   (w_row[gi]),
        .o_neg   (w_neg[gi])
      );
      assign w_all[gi] = P'(w_row[gi]) << (2 * gi);
    end

    for (gi = 0; gi < P; gi++) begin : g_negbit
      if ((gi % 2 == 0) && (gi / 2 < NPP)) begin : g_on
        assign w_neg_row[gi] = w_neg[gi/2];
      end else begin : g_off
        assign w_neg_row[gi] = 1'b0;
      end
    end
    assign w_all[NPP]     = w_neg_row;
    assign w_all[NPP + 1] = SE_CONST;

    // Level gi reads its rows from the flat array and writes level gi+1 after them.
    for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
      localparam int IN  = row_base(N0, gi);
      localparam int OUT = row_base(N0, gi + 1);
      localparam int M   = rows_at(N0, gi);
      for (gj = 0; gj < M / 3; gj++) begin : g_csa
        assign w_all[OUT+2*gj]   = w_all[IN+3*gj] ^ w_all[IN+3*gj+1] ^ w_all[IN+3*gj+2];
        assign w_all[OUT+2*gj+1] = ((w_all[IN+3*gj] & w_all[IN+3*gj+1]) |
                                    (w_all[IN+3*gj] & w_all[IN+3*gj+2]) |
                                    (w_all[IN+3*gj+1] & w_all[IN+3*gj+2])) << 1;
      end
      for (gj = 0; gj < M % 3; gj++) begin : g_pass
        assign w_all[OUT+2*(M/3)+gj] = w_all[IN+3*(M/3)+gj];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy     <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_tag1    <= '0;
      r_tag2    <= '0;
      r_sum     <= '0;
      r_carry   <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_adv) begin
        r_v1      <= w_accept;
        r_v2      <= r_v1;
        out_valid <= r_v2;
        if (w_accept) begin
          r_a    <= {{2{in_signed & in_a[WIDTH-1]}}, in_a};
          r_b    <= {{2{in_signed & in_b[WIDTH-1]}}, in_b};
          r_tag1 <= in_tag;
        end
        if (r_v1) begin
          r_sum   <= w_all[FIN];
          r_carry <= w_all[FIN+1];
          r_tag2  <= r_tag1;
        end
        if (r_v2) begin
          out_prod <= r_sum + r_carry;
          out_tag  <= r_tag2;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Bench for booth_mult_pipe: directed 8-bit cases plus random 16/32-bit traffic,
// all scored against a plain-arithmetic multiply model.
module tb_booth_mult_pipe;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
  } exp_t;

  localparam int NOPS = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_w = 1'b1;
  logic       go    = 1'b0;
  logic [1:0] done  = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Product of the two operands as integers, reduced to 2*w bits.
  function automatic logic [63:0] mul_ref(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [127:0] m, ea, eb, p;
    m  = (128'd1 << w) - 128'd1;
    ea = {96'd0, a} & m;
    eb = {96'd0, b} & m;
    if (s && a[w-1]) ea = ea - (128'd1 << w);
    if (s && b[w-1]) eb = eb - (128'd1 << w);
    p = (ea * eb) & ((128'd1 << (2 * w)) - 128'd1);
    return p[63:0];
  endfunction

  // ---------------- 8-bit DUT, directed ----------------
  logic        rst8 = 1'b1;
  logic        v8 = 1'b0, s8 = 1'b0, or8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  t8 = '0;
  logic        ir8, ov8;
  logic [15:0] p8;
  logic [3:0]  ot8;
  exp_t        q8[$];
  int          outs8 = 0;

  booth_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .reset(rst8), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
    .out_prod(p8), .out_tag(ot8)
  );

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic [15:0] exp);
    int n;
    exp_t e;
    a8 = a; b8 = b; s8 = s; t8 = t; v8 = 1'b1;
    @(negedge clk);
    n = 0;
    while (!ir8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) check("send8_ready_timeout", {63'd0, ir8}, 64'd1);
    e.p = {48'd0, exp}; e.t = t; e.a = {24'd0, a}; e.b = {24'd0, b}; e.s = s;
    q8.push_back(e);
    @(posedge clk);
    #1 v8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); t8 = 4'($urandom);
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain8", 64'(q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : chk8
    logic        stall;
    logic [15:0] hp;
    logic [3:0]  ht;
    exp_t        e;
    stall = 1'b0; hp = '0; ht = '0;
    forever begin
      @(negedge clk);
      if (rst8) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", {63'd0, ov8}, 64'd1);
          check("stall_prod", {48'd0, p8}, {48'd0, hp});
          check("stall_tag", {60'd0, ot8}, {60'd0, ht});
        end
        if (ov8 && !or8) check("stall_in_ready", {63'd0, ir8}, 64'd0);
        if (ov8 && or8) begin
          if (q8.size() == 0) begin
            check("w8_spurious_out", {48'd0, p8}, 64'd0);
            check("w8_spurious_valid", {63'd0, ov8}, 64'd0);
          end else begin
            e = q8.pop_front();
            outs8++;
            $display("w8 tag=%h a=%h b=%h s=%0d prod=%h exp=%h", ot8, e.a[7:0], e.b[7:0],
                     e.s, p8, e.p[15:0]);
            check("w8_prod", {48'd0, p8}, e.p);
            check("w8_tag", {60'd0, ot8}, {60'd0, e.t});
          end
        end
        stall = ov8 && !or8;
        hp = p8;
        ht = ot8;
      end
    end
  end

  // ---------------- 16/32-bit DUTs, random ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rnd
      localparam int W = (gi == 0) ? 16 : 32;
      logic           v = 1'b0, s = 1'b0, ordy = 1'b0;
      logic [W-1:0]   a = '0, b = '0;
      logic [3:0]     t = '0;
      logic           ir, ov;
      logic [2*W-1:0] p;
      logic [3:0]     ot;
      exp_t           q[$];
      int             acc_n = 0;

      booth_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
        .clk(clk), .reset(rst_w), .in_valid(v), .in_ready(ir), .in_a(a), .in_b(b),
        .in_signed(s), .in_tag(t), .out_valid(ov), .out_ready(ordy),
        .out_prod(p), .out_tag(ot)
      );

      function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
          0:       return '0;
          1:       return '1;
          2:       return {1'b1, {(W-1){1'b0}}};
          3:       return {1'b0, {(W-1){1'b1}}};
          default: return W'($urandom);
        endcase
      endfunction

      initial begin : drv
        exp_t e;
        int   n;
        wait (go);
        @(posedge clk);
        #1;
        while (acc_n < NOPS) begin
          v = ($urandom_range(0, 3) != 0);
          a = pick();
          b = pick();
          s = 1'($urandom);
          t = 4'($urandom);
          ordy = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (v && ir) begin
            e.a = 32'(a); e.b = 32'(b); e.s = s; e.t = t;
            e.p = mul_ref(W, 32'(a), 32'(b), s);
            q.push_back(e);
            acc_n++;
          end
          @(posedge clk);
          #1;
        end
        v = 1'b0;
        ordy = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        check((W == 16) ? "w16_drain" : "w32_drain", 64'(q.size()), 64'd0);
        done[gi] = 1'b1;
      end

      initial begin : chk
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst_w && ov && ordy) begin
            if (q.size() == 0) begin
              check((W == 16) ? "w16_spurious" : "w32_spurious", {63'd0, ov}, 64'd0);
            end else begin
              e = q.pop_front();
              $display("w%0d tag=%h a=%h b=%h s=%0d prod=%h exp=%h", W, ot, e.a, e.b, e.s,
                       64'(p), e.p);
              check((W == 16) ? "w16_prod" : "w32_prod", 64'(p), e.p);
              check((W == 16) ? "w16_tag" : "w32_tag", {60'd0, ot}, {60'd0, e.t});
            end
          end
        end
      end
    end
  endgenerate

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int t0, o0, n;
    logic [7:0] ra, rb;
    logic       rs;

    // model pins
    check("ref_s_minmin", mul_ref(8, 32'h80, 32'h80, 1'b1), 64'h4000);
    check("ref_s_m1x1", mul_ref(8, 32'hFF, 32'h01, 1'b1), 64'hFFFF);
    check("ref_s_127xm128", mul_ref(8, 32'h7F, 32'h80, 1'b1), 64'hC080);
    check("ref_u_ffxff", mul_ref(8, 32'hFF, 32'hFF, 1'b0), 64'hFE01);
    check("ref_u_80x80", mul_ref(8, 32'h80, 32'h80, 1'b0), 64'h4000);
    check("ref_s16_minmin", mul_ref(16, 32'h8000, 32'h8000, 1'b1), 64'h4000_0000);
    check("ref_u32_ones", mul_ref(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0),
          64'hFFFF_FFFE_0000_0001);

    // reset state
    #12;
    check("rst_out_valid", {63'd0, ov8}, 64'd0);
    check("rst_out_prod", {48'd0, p8}, 64'd0);
    check("rst_out_tag", {60'd0, ot8}, 64'd0);
    check("rst_in_ready", {63'd0, ir8}, 64'd0);
    @(negedge clk);
    rst8 = 1'b0;
    rst_w = 1'b0;
    #1 check("rel_in_ready_low", {63'd0, ir8}, 64'd0);
    @(negedge clk);
    check("rel_in_ready_high", {63'd0, ir8}, 64'd1);
    @(posedge clk);
    #1;

    // directed corners
    send8(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
    send8(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF);
    send8(8'h7F, 8'h80, 1'b1, 4'h3, 16'hC080);
    send8(8'hFF, 8'hFF, 1'b0, 4'h4, 16'hFE01);
    send8(8'h00, 8'hC8, 1'b0, 4'h5, 16'h0000);
    send8(8'h9C, 8'h00, 1'b1, 4'h6, 16'h0000);
    send8(8'h00, 8'hFF, 1'b1, 4'h7, 16'h0000);
    drain8();

    // alternating mode at full throughput
    t0 = cyc;
    for (int i = 0; i < 8; i++) send8(8'h80, 8'h80, 1'(i % 2), 4'(i), 16'h4000);
    check("alt_throughput_cycles", 64'(cyc - t0), 64'd8);
    drain8();

    // backpressure with six back-to-back ops
    o0 = outs8;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
          send8(ra, rb, rs, 4'(8 + i), mul_ref(8, {24'd0, ra}, {24'd0, rb}, rs)[15:0]);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 or8 = 1'b0;
        repeat (5) @(posedge clk);
        #1 or8 = 1'b1;
      end
    join
    drain8();
    check("bp_result_count", 64'(outs8 - o0), 64'd6);

    // reset with three ops in flight
    send8(8'h11, 8'h22, 1'b0, 4'hC, 16'h0242);
    send8(8'hF0, 8'h10, 1'b1, 4'hD, 16'hFF00);
    send8(8'h05, 8'h07, 1'b0, 4'hE, 16'h0023);
    #2 rst8 = 1'b1;
    #1 check("midrst_out_valid", {63'd0, ov8}, 64'd0);
    check("midrst_out_prod", {48'd0, p8}, 64'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_no_stale", {63'd0, ov8}, 64'd0);
    end
    @(posedge clk);
    #1;
    send8(8'h12, 8'h34, 1'b0, 4'hA, 16'h03A8);
    @(negedge clk);
    check("lat_cycle1", {63'd0, ov8}, 64'd0);
    @(negedge clk);
    check("lat_cycle2", {63'd0, ov8}, 64'd0);
    @(negedge clk);
    check("lat_cycle3", {63'd0, ov8}, 64'd1);
    drain8();

    // wide random traffic
    go = 1'b1;
    n = 0;
    while (done != 2'b11 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("rnd_done", {62'd0, done}, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
